// File: rtl/exe_div_seq.sv
// exe_div_seq: multi-cycle RV32M DIV/DIVU/REM/REMU sequencer for the execute stage.
// Radix-2 restoring division, one quotient bit per cycle. Divide-by-zero and
// signed overflow resolve without iterating.
// Ports:
//   clk_i, rst_i        clock, synchronous active-high reset
//   start_i             divide-class instruction present in exe this cycle
//   funct3_i            bit0=0 signed, bit1=1 remainder
//   dividend_i          rs1 value
//   divisor_i           rs2 value
//   reg_waddr_i         destination register
//   flush_i             abort current operation
//   busy_o              stall request to pipe_ctrl
//   done_o              one-cycle result-valid pulse
//   result_o            quotient or remainder (zero outside DONE)
//   reg_waddr_o         latched destination (zero outside DONE)
//   reg_we_o            write enable, equals done_o
module exe_div_seq #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned CNT_WIDTH  = 5
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  start_i,
    input  logic [2:0]            funct3_i,
    input  logic [DATA_WIDTH-1:0] dividend_i,
    input  logic [DATA_WIDTH-1:0] divisor_i,
    input  logic [4:0]            reg_waddr_i,
    input  logic                  flush_i,
    output logic                  busy_o,
    output logic                  done_o,
    output logic [DATA_WIDTH-1:0] result_o,
    output logic [4:0]            reg_waddr_o,
    output logic                  reg_we_o
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CALC = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam logic [CNT_WIDTH-1:0]  LAST_CNT = CNT_WIDTH'(DATA_WIDTH - 1);
    localparam logic [DATA_WIDTH-1:0] MIN_NEG  = {1'b1, {(DATA_WIDTH-1){1'b0}}};

    logic [1:0]            state_q, state_d;
    logic [CNT_WIDTH-1:0]  cnt_q;
    logic [DATA_WIDTH-1:0] rem_q, quot_q, dvsr_q, result_q;
    logic [4:0]            waddr_q;
    logic                  is_rem_q, neg_quot_q, neg_rem_q;

    logic                  accept, is_signed, is_rem, div_zero, overflow;
    logic                  dvd_neg, dvs_neg, last;
    logic [DATA_WIDTH-1:0] dvd_abs, dvs_abs;
    logic [DATA_WIDTH:0]   shifted, diff;
    logic [DATA_WIDTH-1:0] rem_next, quot_next, rem_fix, quot_fix;
    logic                  unused_funct3;

    assign unused_funct3 = funct3_i[2];

    // Operand decode and special-case detection at acceptance.
    always_comb begin
        accept    = (state_q == S_IDLE) & start_i & ~flush_i;
        is_signed = ~funct3_i[0];
        is_rem    = funct3_i[1];
        div_zero  = (divisor_i == '0);
        overflow  = is_signed & (dividend_i == MIN_NEG) & (divisor_i == '1);
        dvd_neg   = is_signed & dividend_i[DATA_WIDTH-1];
        dvs_neg   = is_signed & divisor_i[DATA_WIDTH-1];
        dvd_abs   = dvd_neg ? (DATA_WIDTH'(0) - dividend_i) : dividend_i;
        dvs_abs   = dvs_neg ? (DATA_WIDTH'(0) - divisor_i) : divisor_i;
    end

    // One restoring-division step; diff[DATA_WIDTH] set means the trial went negative.
    always_comb begin
        shifted   = {rem_q, quot_q[DATA_WIDTH-1]};
        diff      = shifted - {1'b0, dvsr_q};
        rem_next  = diff[DATA_WIDTH] ? shifted[DATA_WIDTH-1:0] : diff[DATA_WIDTH-1:0];
        quot_next = {quot_q[DATA_WIDTH-2:0], ~diff[DATA_WIDTH]};
        rem_fix   = neg_rem_q  ? (DATA_WIDTH'(0) - rem_next)  : rem_next;
        quot_fix  = neg_quot_q ? (DATA_WIDTH'(0) - quot_next) : quot_next;
        last      = (cnt_q == LAST_CNT);
    end

    // State register.
    always_ff @(posedge clk_i) begin
        if (rst_i) state_q <= S_IDLE;
        else       state_q <= state_d;
    end

    // Next-state and output decode.
    always_comb begin
        state_d     = state_q;
        busy_o      = 1'b0;
        done_o      = 1'b0;
        reg_we_o    = 1'b0;
        result_o    = '0;
        reg_waddr_o = '0;
        case (state_q)
            S_IDLE: begin
                busy_o = start_i & ~flush_i;
                if (accept) state_d = (div_zero | overflow) ? S_DONE : S_CALC;
            end
            S_CALC: begin
                busy_o = 1'b1;
                if (flush_i)   state_d = S_IDLE;
                else if (last) state_d = S_DONE;
            end
            S_DONE: begin
                // start_i here still belongs to the instruction just finished.
                done_o      = 1'b1;
                reg_we_o    = 1'b1;
                result_o    = result_q;
                reg_waddr_o = waddr_q;
                state_d     = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Datapath registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q      <= '0;
            rem_q      <= '0;
            quot_q     <= '0;
            dvsr_q     <= '0;
            result_q   <= '0;
            waddr_q    <= '0;
            is_rem_q   <= 1'b0;
            neg_quot_q <= 1'b0;
            neg_rem_q  <= 1'b0;
        end else if (accept) begin
            is_rem_q <= is_rem;
            waddr_q  <= reg_waddr_i;
            if (div_zero) begin
                result_q <= is_rem ? dividend_i : '1;
            end else if (overflow) begin
                result_q <= is_rem ? '0 : MIN_NEG;
            end else begin
                quot_q     <= dvd_abs;
                dvsr_q     <= dvs_abs;
                rem_q      <= '0;
                cnt_q      <= '0;
                neg_quot_q <= dvd_neg ^ dvs_neg;
                neg_rem_q  <= dvd_neg;
            end
        end else if ((state_q == S_CALC) && !flush_i) begin
            rem_q  <= rem_next;
            quot_q <= quot_next;
            cnt_q  <= cnt_q + CNT_WIDTH'(1);
            if (last) result_q <= is_rem_q ? rem_fix : quot_fix;
        end
    end

endmodule

// File: tb/tb_exe_div_seq.sv
// Self-checking bench for exe_div_seq against an arithmetic reference model.
module tb_exe_div_seq;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [2:0]  funct3 = '0;
    logic [31:0] dividend = '0;
    logic [31:0] divisor = '0;
    logic [4:0]  waddr = '0;
    logic        flush = 1'b0;
    logic        busy, done, we;
    logic [31:0] result;
    logic [4:0]  waddr_out;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    exe_div_seq #(.DATA_WIDTH(32), .CNT_WIDTH(5)) dut (
        .clk_i(clk), .rst_i(rst), .start_i(start), .funct3_i(funct3),
        .dividend_i(dividend), .divisor_i(divisor), .reg_waddr_i(waddr),
        .flush_i(flush), .busy_o(busy), .done_o(done), .result_o(result),
        .reg_waddr_o(waddr_out), .reg_we_o(we)
    );

    // RISC-V M semantics: expected result and cycle in which done appears.
    function automatic void model(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] r, output int lat);
        bit sg = !f[0];
        bit rm = f[1];
        if (b == 32'd0) begin
            r = rm ? a : 32'hFFFF_FFFF;
            lat = 1;
        end else if (sg && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            r = rm ? 32'd0 : 32'h8000_0000;
            lat = 1;
        end else begin
            lat = 33;
            if (sg) begin
                longint sa = longint'($signed(a));
                longint sb = longint'($signed(b));
                r = rm ? 32'(sa % sb) : 32'(sa / sb);
            end else begin
                r = rm ? a % b : a / b;
            end
        end
    endfunction

    // Advance one cycle; inputs change 1 after the edge, outputs sampled 2 after.
    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic scramble_inputs();
        dividend = $urandom;
        divisor  = $urandom;
        funct3   = 3'($urandom);
        waddr    = 5'($urandom);
    endtask

    // One operation with start held for cycle 0 only; inputs scrambled afterwards.
    task automatic run_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                          input logic [4:0] wa, input string tag);
        logic [31:0] exp;
        int lat;
        bit seen;
        model(f, a, b, exp, lat);
        next_cycle();
        start = 1'b1; funct3 = f; dividend = a; divisor = b; waddr = wa;
        #1;
        vectors++;
        if (busy !== 1'b1) begin
            miscompares++;
            $display("FAIL %s busy_c0: got %b want 1", tag, busy);
        end
        seen = 0;
        for (int c = 1; c <= 40 && !seen; c++) begin
            next_cycle();
            start = 1'b0;
            scramble_inputs();
            #1;
            if (done === 1'b1) begin
                seen = 1;
                vectors++;
                if (c !== lat || result !== exp || waddr_out !== wa || we !== 1'b1 || busy !== 1'b0) begin
                    miscompares++;
                    $display("FAIL %s done: cyc=%0d res=%h wa=%0d we=%b busy=%b want cyc=%0d res=%h wa=%0d we=1 busy=0",
                             tag, c, result, waddr_out, we, busy, lat, exp, wa);
                end
            end else if (busy !== 1'b1) begin
                vectors++;
                miscompares++;
                $display("FAIL %s busy_calc: cyc=%0d got %b want 1", tag, c, busy);
            end
        end
        if (!seen) begin
            vectors++;
            miscompares++;
            $display("FAIL %s timeout: no done within 40 cycles, want cyc=%0d", tag, lat);
        end
        next_cycle();
        #1;
        vectors++;
        if (done !== 1'b0 || we !== 1'b0 || result !== 32'd0 || waddr_out !== 5'd0) begin
            miscompares++;
            $display("FAIL %s idle_after: done=%b we=%b res=%h wa=%0d want all 0", tag, done, we, result, waddr_out);
        end
    endtask

    // Watch n cycles with start low; no done may appear.
    task automatic expect_quiet(input int n, input string tag);
        bit bad = 0;
        start = 1'b0;
        for (int c = 0; c < n; c++) begin
            next_cycle();
            #1;
            if (done !== 1'b0 || busy !== 1'b0) bad = 1;
        end
        vectors++;
        if (bad) begin
            miscompares++;
            $display("FAIL %s quiet: done/busy seen, want both 0 for %0d cycles", tag, n);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0;
        next_cycle(); next_cycle();
        #1;
        vectors++;
        if ({busy, done, we, result, waddr_out} !== '0) begin
            miscompares++;
            $display("FAIL reset_outs: busy=%b done=%b we=%b res=%h wa=%0d want 0", busy, done, we, result, waddr_out);
        end
        start = 1'b1;
        #1;
        vectors++;
        if (busy !== 1'b1 || done !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_busy_eq: busy=%b done=%b want busy=1 done=0", busy, done);
        end
        next_cycle();
        start = 1'b0; rst = 1'b0;
    endtask

    task automatic test_directed();
        run_op(3'b101, 32'd100, 32'd7, 5'd1, "divu_100_7");
        run_op(3'b111, 32'd100, 32'd7, 5'd2, "remu_100_7");
        run_op(3'b100, -32'sd7, 32'd2, 5'd3, "div_m7_2");
        run_op(3'b110, -32'sd7, 32'd2, 5'd4, "rem_m7_2");
        run_op(3'b100, 32'd7, -32'sd2, 5'd5, "div_7_m2");
        run_op(3'b110, 32'd7, -32'sd2, 5'd6, "rem_7_m2");
        run_op(3'b100, 32'd5, 32'd0, 5'd7, "div_by0");
        run_op(3'b111, 32'd5, 32'd0, 5'd8, "remu_by0");
        run_op(3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 5'd9, "div_ovf");
        run_op(3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 5'd10, "rem_ovf");
        run_op(3'b101, 32'h8000_0000, 32'hFFFF_FFFF, 5'd11, "divu_big");
        run_op(3'b101, 32'hFFFF_FFFF, 32'd1, 5'd31, "divu_max");
    endtask

    task automatic test_random();
        for (int i = 0; i < 40; i++) begin
            logic [2:0]  f = 3'($urandom);
            logic [31:0] a = $urandom;
            logic [31:0] b = $urandom;
            int sel = $urandom_range(0, 7);
            if (sel == 0) b = 32'd0;
            else if (sel == 1) begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; f[0] = 1'b0; end
            else if (sel == 2) b = 32'($urandom_range(1, 300));
            else if (sel == 3) a = 32'($urandom_range(0, 1000));
            run_op(f, a, b, 5'($urandom), "random");
        end
    endtask

    task automatic test_flush();
        next_cycle();
        start = 1'b1; funct3 = 3'b101; dividend = 32'hDEAD_BEEF; divisor = 32'd13; waddr = 5'd12;
        for (int c = 1; c <= 10; c++) begin
            next_cycle();
            start = 1'b0;
        end
        flush = 1'b1;
        next_cycle();
        flush = 1'b0;
        #1;
        vectors++;
        if (busy !== 1'b0 || done !== 1'b0 || we !== 1'b0) begin
            miscompares++;
            $display("FAIL flush_calc: busy=%b done=%b we=%b want 0", busy, done, we);
        end
        expect_quiet(40, "flush_calc");
        // Flush beats start in IDLE.
        start = 1'b1; flush = 1'b1; funct3 = 3'b101; dividend = 32'd50; divisor = 32'd5;
        #1;
        vectors++;
        if (busy !== 1'b0) begin
            miscompares++;
            $display("FAIL flush_idle_busy: got %b want 0", busy);
        end
        next_cycle();
        flush = 1'b0;
        expect_quiet(40, "flush_idle");
        run_op(3'b101, 32'd9, 32'd3, 5'd13, "divu_after_flush");
    endtask

    task automatic test_back_to_back();
        bit early = 0;
        bit seen = 0;
        next_cycle();
        start = 1'b1; funct3 = 3'b101; dividend = 32'd100; divisor = 32'd7; waddr = 5'd14;
        for (int c = 1; c <= 33; c++) begin
            next_cycle();
            #1;
            if (c < 33 && done !== 1'b0) early = 1;
        end
        vectors++;
        if (done !== 1'b1 || result !== 32'd14 || waddr_out !== 5'd14) begin
            miscompares++;
            $display("FAIL b2b_first: done=%b res=%h wa=%0d want done=1 res=0000000e wa=14 (early=%0d)",
                     done, result, waddr_out, early);
        end
        vectors++;
        if (early) begin
            miscompares++;
            $display("FAIL b2b_early: done seen before cycle 33, want none");
        end
        next_cycle();
        funct3 = 3'b100; dividend = -32'sd7; divisor = 32'd2; waddr = 5'd15;
        #1;
        vectors++;
        if (busy !== 1'b1 || done !== 1'b0) begin
            miscompares++;
            $display("FAIL b2b_accept34: busy=%b done=%b want busy=1 done=0", busy, done);
        end
        for (int c = 35; c <= 80 && !seen; c++) begin
            next_cycle();
            start = 1'b0;
            scramble_inputs();
            #1;
            if (done === 1'b1) begin
                seen = 1;
                vectors++;
                if (c !== 67 || result !== 32'hFFFF_FFFD || waddr_out !== 5'd15) begin
                    miscompares++;
                    $display("FAIL b2b_second: cyc=%0d res=%h wa=%0d want cyc=67 res=fffffffd wa=15",
                             c, result, waddr_out);
                end
            end
        end
        if (!seen) begin
            vectors++;
            miscompares++;
            $display("FAIL b2b_second timeout: no done by cycle 80, want cyc=67");
        end
        next_cycle();
    endtask

    task automatic test_reset_mid();
        next_cycle();
        start = 1'b1; funct3 = 3'b110; dividend = 32'd12345; divisor = 32'd17; waddr = 5'd16;
        for (int c = 1; c <= 20; c++) begin
            next_cycle();
            start = 1'b0;
        end
        rst = 1'b1;
        next_cycle();
        rst = 1'b0;
        #1;
        vectors++;
        if ({busy, done, we, result, waddr_out} !== '0) begin
            miscompares++;
            $display("FAIL reset_mid: busy=%b done=%b we=%b res=%h wa=%0d want 0", busy, done, we, result, waddr_out);
        end
        expect_quiet(40, "reset_mid");
        run_op(3'b111, 32'd12345, 32'd17, 5'd17, "remu_after_reset");
    endtask

    initial begin
        test_reset();
        test_directed();
        test_flush();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
